// File: rtl/cut_sweep_pkg.sv
// rtl/cut_sweep_pkg.sv - shared state encoding, default MISR constants and MISR step
// for the exhaustive CUT sweep controller.
package cut_sweep_pkg;

  localparam int MISR_MAX = 32;
  localparam logic [MISR_MAX-1:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [MISR_MAX-1:0] DEF_SEED = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  // One MISR step on the low w bits of the word; bits above w come back as zero.
  function automatic logic [MISR_MAX-1:0] misr_next(
    input logic [MISR_MAX-1:0] sig,
    input logic [MISR_MAX-1:0] data,
    input logic [MISR_MAX-1:0] poly,
    input int                  w
  );
    logic [MISR_MAX-1:0] mask;
    logic [MISR_MAX-1:0] top;
    mask = {MISR_MAX{1'b1}} >> (MISR_MAX - w);
    top  = mask ^ (mask >> 1);
    return ((sig << 1) ^ ((|(sig & top)) ? poly : '0) ^ data) & mask;
  endfunction

endpackage

// File: rtl/cut_misr.sv
// rtl/cut_misr.sv - signature register: clear-to-SEED has priority over the
// enabled fold of one CUT output vector.
module cut_misr
  import cut_sweep_pkg::*;
#(
  parameter int                  MISR_W = 32,
  parameter int                  N_OUT  = 28,
  parameter logic [MISR_MAX-1:0] POLY   = DEF_POLY,
  parameter logic [MISR_MAX-1:0] SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [N_OUT-1:0]  data_i,
  output logic [MISR_W-1:0] sig_o
);

  logic [MISR_W-1:0]   sig_q, sig_d;
  logic [MISR_MAX-1:0] sig_ext, data_ext, step;

  always_comb begin
    sig_ext                = '0;
    sig_ext[MISR_W-1:0]    = sig_q;
    data_ext               = '0;
    data_ext[N_OUT-1:0]    = data_i;
    step                   = misr_next(sig_ext, data_ext, POLY, MISR_W);
    sig_d                  = sig_q;
    if (clr_i) begin
      sig_d = SEED[MISR_W-1:0];
    end else if (en_i) begin
      sig_d = step[MISR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED[MISR_W-1:0];
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/cut_sweep_ctrl.sv
// rtl/cut_sweep_ctrl.sv - exhaustive-sweep controller: drives all 2^N_IN vectors into
// the CUT, folds its outputs into a MISR and checks it. Option: CUT_SWEEP_ONES_COUNT_EN.
module cut_sweep_ctrl
  import cut_sweep_pkg::*;
#(
  parameter int                  N_IN       = 10,
  parameter int                  N_OUT      = 28,
  parameter int                  MISR_W     = 32,
  parameter logic [MISR_MAX-1:0] POLY       = DEF_POLY,
  parameter logic [MISR_MAX-1:0] SEED       = DEF_SEED,
  parameter int                  SETTLE_CYC = 1
`ifdef CUT_SWEEP_ONES_COUNT_EN
  ,parameter int                 CNT_IDX_A  = 0,
  parameter int                  CNT_IDX_B  = 7
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [MISR_W-1:0] exp_sig,
  output logic [N_IN-1:0]   cut_x,
  input  logic [N_OUT-1:0]  cut_f,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] sig,
  output logic [N_IN-1:0]   vec_idx
`ifdef CUT_SWEEP_ONES_COUNT_EN
  ,output logic [N_IN:0]    ones_a,
  output logic [N_IN:0]     ones_b
`endif
);

  // One extra index bit keeps the terminal compare clear of the wrap to zero.
  localparam logic [N_IN:0] LAST_IDX    = {1'b0, {N_IN{1'b1}}};
  localparam logic [N_IN:0] IDX_ONE     = {{N_IN{1'b0}}, 1'b1};
  localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [N_IN:0]     vec_q, vec_d;
  logic [N_IN-1:0]   cut_x_q, cut_x_d;
  logic [MISR_W-1:0] exp_q, exp_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              sweep_clr, cap_en, running;

  assign running = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cut_x_d   = cut_x_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    sweep_clr = 1'b0;
    cap_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_APPLY;
          vec_d     = '0;
          exp_d     = exp_sig;
          sweep_clr = 1'b1;
        end
      end
      ST_APPLY: begin
        cut_x_d = vec_q[N_IN-1:0];
        if (SETTLE_CYC > 0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_CAPTURE: begin
        cap_en = 1'b1;
        if (vec_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + IDX_ONE;
          state_d = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort outranks everything, including the final capture; results stay frozen.
    if (running && abort) begin
      state_d = ST_IDLE;
      vec_d   = vec_q;
      cut_x_d = cut_x_q;
      cnt_d   = cnt_q;
      cap_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cut_x_q <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cut_x_q <= cut_x_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
    end
  end

  cut_misr #(
    .MISR_W (MISR_W),
    .N_OUT  (N_OUT),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (sweep_clr),
    .en_i   (cap_en),
    .data_i (cut_f),
    .sig_o  (sig)
  );

  assign busy    = running;
  assign done    = (state_q == ST_DONE);
  assign pass    = done && (sig == exp_q);
  assign cut_x   = cut_x_q;
  assign vec_idx = vec_q[N_IN-1:0];

`ifdef CUT_SWEEP_ONES_COUNT_EN
  logic [N_IN:0] ones_a_q, ones_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_a_q <= '0;
      ones_b_q <= '0;
    end else if (sweep_clr) begin
      ones_a_q <= '0;
      ones_b_q <= '0;
    end else if (cap_en) begin
      ones_a_q <= ones_a_q + {{N_IN{1'b0}}, cut_f[CNT_IDX_A]};
      ones_b_q <= ones_b_q + {{N_IN{1'b0}}, cut_f[CNT_IDX_B]};
    end
  end

  assign ones_a = ones_a_q;
  assign ones_b = ones_b_q;
`endif

endmodule
